// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: run/step/burst execution controller driven by board buttons.
// Debounces three raw buttons and issues a registered one-cycle cpu_en at a
// programmable rate while running, or for a single step / counted burst.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_STOP  | idle, waiting for a run, step or burst press
//   ST_RUN   | free-running, cpu_en once per div+1 cycles
//   ST_STEP  | single cycle with cpu_en high, then back to ST_STOP
//   ST_BURST | cpu_en once per div+1 cycles until rem pulses have issued
module clk_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int BW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_run,
    input  logic          btn_step,
    input  logic          btn_burst,
    input  logic          halt,
    input  logic [31:0]   div,
    input  logic [BW-1:0] burst_len,
    output logic          cpu_en,
    output logic [1:0]    state,
    output logic [31:0]   cycles
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t        st;
    logic [31:0]   pc;
    logic [BW-1:0] rem;

    // Bit order for all button vectors: [2] burst, [1] step, [0] run.
    logic [2:0]    btn_raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    db;
    logic [2:0]    db_prev;
    logic [2:0]    p;
    logic [CW-1:0] cnt [3];

    logic p_run;
    logic p_step;
    logic p_burst;

    assign btn_raw = {btn_burst, btn_step, btn_run};
    assign p_run   = p[0];
    assign p_step  = p[1];
    assign p_burst = p[2];
    assign state   = st;

    // Two-flop synchroniser and registered rising-edge press detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            db_prev <= '0;
            p       <= '0;
        end else begin
            s1      <= btn_raw;
            s2      <= s1;
            db_prev <= db;
            p       <= db & ~db_prev;
        end
    end

    // Debounce: the level only follows s2 after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sequencing FSM with prescaler and burst down-counter; cpu_en is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= ST_STOP;
            cpu_en <= 1'b0;
            pc     <= '0;
            rem    <= '0;
        end else begin
            cpu_en <= 1'b0;
            case (st)
                ST_STOP: begin
                    if (p_run && !halt) begin
                        st <= ST_RUN;
                        pc <= div;
                    end else if (p_step) begin
                        st     <= ST_STEP;
                        cpu_en <= 1'b1;
                    end else if (p_burst && !halt && (burst_len != '0)) begin
                        st  <= ST_BURST;
                        rem <= burst_len;
                        pc  <= div;
                    end
                end
                ST_STEP: begin
                    st <= ST_STOP;
                end
                ST_RUN: begin
                    if (p_run || halt) begin
                        st <= ST_STOP;
                    end else if (pc == '0) begin
                        cpu_en <= 1'b1;
                        pc     <= div;
                    end else begin
                        pc <= pc - 32'd1;
                    end
                end
                ST_BURST: begin
                    // rem reaching zero means the last pulse is already out;
                    // leave one cycle later so STOP follows the final pulse.
                    if (p_run || halt || (rem == '0)) begin
                        st  <= ST_STOP;
                        rem <= '0;
                    end else if (pc == '0) begin
                        cpu_en <= 1'b1;
                        pc     <= div;
                        rem    <= rem - 1'b1;
                    end else begin
                        pc <= pc - 32'd1;
                    end
                end
                default: st <= ST_STOP;
            endcase
        end
    end

    // Count issued enables, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else if (cpu_en) begin
            cycles <= cycles + 32'd1;
        end
    end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Run/step controller that sequences the computer's execution from the board buttons. It debounces run, step and burst buttons and tracks a stop/run/step/burst state machine. It produces a one-cycle clock-enable `cpu_en` at a programmable rate. It sits between the raw button inputs and `comp`, in the `selected_clk` domain, and replaces fixed-rate clock selection with single-cycle and counted-burst execution for debugging.

## Interface
- `DEB_CYCLES`, 16: consecutive stable cycles required before a debounced button level changes (≥1).
- `BW`, 16: width of burst length and burst down-counter.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `btn_run`  in  1  raw run/stop toggle button (asynchronous, bouncy).
- `btn_step`  in  1  raw single-step button.
- `btn_burst`  in  1  raw burst button.
- `halt`  in  1  CPU halt request, synchronous level.
- `div`  in  32  prescaler reload; RUN/BURST pulse period is div+1 cycles.
- `burst_len`  in  BW  number of enables issued per burst.
- `cpu_en`  out  1  registered clock-enable pulse to the CPU.
- `state`  out  2  current FSM state: 0 STOP, 1 RUN, 2 STEP, 3 BURST.
- `cycles`  out  32  count of `cpu_en` pulses issued, wraps modulo 2^32.

## Operation
- **Button path** (identical for all three buttons):
  - Two-flop synchroniser produces `s2`.
  - Debounced level `db` and counter `cnt`:
    - If `s2`==`db`, `cnt`<=0.
    - Otherwise `cnt` increments. When `cnt`==DEB_CYCLES-1 and `s2` still differs, `db`<=`s2` and `cnt`<=0.
  - Press pulse `p` is registered: `p`<=`db` & ~`db_prev`, high for exactly one cycle per debounced rising edge.
  - A release never generates a pulse.
- **STOP**:
  - `p_run` & ~`halt` -> RUN.
  - Else `p_step` -> STEP.
  - Else `p_burst` & ~`halt` & `burst_len`!=0 -> BURST, with `rem`<=`burst_len`.
  - Priority when presses coincide: run > step > burst.
  - A burst press with `burst_len`==0 is ignored.
  - STEP is allowed while `halt` is high, so the CPU can be stepped past a halt.
- **RUN**: `p_run` or `halt` -> STOP. Otherwise `cpu_en` pulses once per div+1 cycles.
- **STEP**: lasts exactly one cycle with `cpu_en`=1, then STOP unconditionally. Presses arriving in that cycle are dropped.
- **BURST**: one `cpu_en` per prescaler expiry, with `rem` decrementing on each pulse.
  - When the pulse with `rem`==1 issues -> STOP.
  - `p_run` or `halt` -> STOP immediately; the remaining count is discarded.
  - Step and burst presses are ignored in RUN and BURST.
- **Prescaler `pc`** (32 bit):
  - Loads `div` on every entry to RUN or BURST.
  - In RUN/BURST: if `pc`==0, a pulse is due and `pc`<=`div`; else `pc`<=`pc`-1.
  - `div`==0 gives a pulse every cycle.
  - `div` changes take effect at the next reload.
- **`cycles`**: increments on every cycle where `cpu_en`=1; 0xFFFFFFFF wraps to 0.
- **Reset** (async): `state`=STOP, `cpu_en`=0, `cycles`=0, `pc`=0, `rem`=0. Synchronisers, `db`, `db_prev`, `cnt` and press pulses all clear to 0. A button held through reset release produces a press once debounced.

## Timing
- **Press latency:** raw edge before clock edge t:
  - `s2` changes at t+2.
  - `db` flips at t+2+DEB_CYCLES.
  - `p` is high in cycle t+3+DEB_CYCLES.
  - `state` holds the new value from t+4+DEB_CYCLES.
- **Bounce filtering:** a raw change reverting before DEB_CYCLES stable `s2` cycles never changes `db`.
- **`cpu_en` is registered:**
  - STEP: `cpu_en` is high in the same cycle `state`==2.
  - RUN/BURST: the first pulse occurs div+1 cycles after `state` first shows RUN/BURST, then every div+1 cycles.
  - Exiting RUN/BURST on `p_run` or `halt`: no `cpu_en` in the cycle `state` first shows STOP.
- **BURST length:** exactly `burst_len` pulses. `state` shows STOP in the cycle after the last pulse.
- **`halt` response:** `halt` sampled high in RUN/BURST -> `state`==STOP next cycle, and no pulse in that next cycle.

## Test plan
- **Reset:** assert `reset` mid-run with `div`=0 -> `cpu_en`, `state` and `cycles` are 0 immediately (async). After release, no pulses until a new press.
- **Single step:** DEB_CYCLES=4, press `btn_step` once -> exactly one `cpu_en`, `state` sequence 0->2->0, `cycles`=1. The STEP cycle occurs 8 cycles after the raw edge.
- **Bounce:** DEB_CYCLES=4, `btn_step` pulses high for 3 cycles, three times -> no `cpu_en`, `state` stays 0. Holding it 4+ cycles -> one step.
- **Run:** `div`=2, press run -> `cpu_en` every 3rd cycle, first pulse 3 cycles after entering RUN. After 30 cycles of RUN, `cycles`=10. Press run again -> STOP with no further pulses.
- **Burst:** `burst_len`=5, `div`=1 -> exactly 5 pulses 2 cycles apart, then STOP, `cycles`=5. With `burst_len`=0, a burst press leaves `state`=0.
- **Halt:** `halt`=1 during RUN -> STOP next cycle. With `halt` held, a run press is ignored and a step press still yields one `cpu_en`. Simultaneous run and step presses in STOP with `halt`=0 -> RUN.
